// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Start/busy/done handshake; the result register holds between conversions.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  function automatic bit digits_ok();
    longint unsigned p;
    bit big;
    p   = 64'd1;
    big = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (p > 64'd1000000000000000000) big = 1'b1;
      else p = p * 64'd10;
    end
    return big || (p > ((64'd1 << WIDTH) - 64'd1));
  endfunction

  if (WIDTH < 2) begin : g_wchk
    $error("bin_to_bcd_seq: WIDTH must be at least 2");
  end
  if (!digits_ok()) begin : g_dchk
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [SW-1:0]   scr_q, scr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   bcd_q, bcd_d;

  logic [SW-1:0]    adj;
  logic [SW-1:0]    scr_sh;
  logic [WIDTH-1:0] bin_sh;

  // Add-3 correction happens before the shift so no digit overflows past 9.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
    scr_sh = {adj[SW-2:0], bin_q[WIDTH-1]};
    bin_sh = {bin_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          bin_d   = bin;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = bin_sh;
        scr_d = scr_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          bcd_d   = scr_sh;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: handshake timing, results,
// start-while-busy, back-to-back, async reset and a full operand sweep.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int errors = 0;
  int checks = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, then watch busy/done; checks latency and result.
  task automatic convert(input int v, input string tag);
    int k;
    int nbusy;
    logic [11:0] exp;
    exp   = ref_bcd(v);
    start = 1'b1;
    bin   = 8'(v);
    step();
    start = 1'b0;
    bin   = 8'hxx;
    k     = 0;
    nbusy = 0;
    while (!done && k < 20) begin
      if (busy) nbusy++;
      step();
      k++;
    end
    chk({tag, "_lat"}, k, 8);
    chk({tag, "_busy"}, nbusy, 8);
    chk({tag, "_bcd"}, bcd, exp);
    chk({tag, "_excl"}, busy, 1'b0);
    chk({tag, "_digits_ok"},
        (bcd[3:0] <= 9) && (bcd[7:4] <= 9) && (bcd[11:8] <= 9), 1'b1);
  endtask

  initial begin
    int k;
    int ndone;
    int last_done;
    int seen;
    bit stable;
    logic [11:0] held;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bcd", bcd, 12'h000);
    rst_n = 1'b1;
    step();

    convert(255, "c255");
    chk("c255_hex", bcd, 12'h255);
    step();
    chk("c255_done_pulse", done, 1'b0);
    chk("c255_hold", bcd, 12'h255);
    step();
    convert(0, "c0");
    convert(99, "c99");
    chk("c99_hex", bcd, 12'h099);
    step();
    convert(200, "c200");
    chk("c200_hex", bcd, 12'h200);
    step();

    // Start with 123, then pulse start with 45 while busy.
    start = 1'b1;
    bin   = 8'd123;
    step();
    start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 3 || c == 5);
      bin   = (c == 3 || c == 5) ? 8'd45 : 8'd99;
      if (done) ndone++;
      step();
    end
    start = 1'b0;
    chk("ign_ndone", ndone, 1);
    chk("ign_bcd", bcd, 12'h123);
    chk("ign_idle", busy, 1'b0);

    // Back-to-back with start held high.
    start     = 1'b1;
    bin       = 8'd10;
    seen      = 0;
    last_done = -1;
    stable    = 1'b1;
    held      = bcd;
    for (int c = 1; c <= 30 && seen < 3; c++) begin
      step();
      if (done) begin
        if (seen == 0) chk("b2b_bcd0", bcd, 12'h010);
        if (seen == 1) chk("b2b_bcd1", bcd, 12'h250);
        if (seen == 2) chk("b2b_bcd2", bcd, 12'h010);
        if (last_done >= 0) chk("b2b_period", c - last_done, 9);
        last_done = c;
        held      = bcd;
        bin       = (seen % 2 == 0) ? 8'd250 : 8'd10;
        seen++;
      end else if (bcd !== held) begin
        stable = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", seen, 3);
    chk("b2b_stable", stable, 1'b1);
    step();
    step();

    // Async reset in the middle of a conversion.
    convert(77, "c77");
    chk("c77_hex", bcd, 12'h077);
    step();
    start = 1'b1;
    bin   = 8'd200;
    step();
    start = 1'b0;
    step();
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_bcd", bcd, 12'h000);
    #7;
    rst_n = 1'b1;
    step();
    chk("arst_nodone", done, 1'b0);
    convert(31, "c31");
    chk("c31_hex", bcd, 12'h031);
    step();

    for (int v = 0; v < 256; v++) begin
      k = $urandom_range(0, 3);
      for (int g = 0; g < k; g++) step();
      convert(v, "sweep");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
